// File: rtl/mont_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mont_pkg
// Purpose : Shared FSM state type and width helpers for the Montgomery core.
// Revision: 1.0 - initial release
// ============================================================================
package mont_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TBL  = 3'd1,
    ST_ITER = 3'd2,
    ST_RED  = 3'd3,
    ST_FIN  = 3'd4
  } mont_state_e;

  function automatic int ndig(input int nbits, input int pbits);
    return nbits / pbits;
  endfunction

  // Accumulator stays below 2m, so two guard bits above NBITS suffice.
  function automatic int acc_width(input int nbits);
    return nbits + 2;
  endfunction

  function automatic int sum_width(input int nbits, input int pbits);
    return nbits + pbits + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mont_digit_step.sv
`default_nettype none
// ============================================================================
// Module  : mont_digit_step
// Purpose : One radix-2^PBITS Montgomery digit step (combinational).
// Revision: 1.0 - initial release
// ============================================================================
module mont_digit_step
  import mont_pkg::*;
#(
  parameter int NBITS  = 4096,
  parameter int PBITS  = 1,
  parameter int MLSIZE = 1 << PBITS
) (
  input  logic [NBITS+1:0]       t,
  input  logic [PBITS-1:0]       d,
  input  logic [PBITS-1:0]       minv,
  input  logic [NBITS+PBITS-1:0] mxn [1:MLSIZE],
  input  logic [NBITS-1:0]       bxn [1:MLSIZE-1],
  output logic [NBITS+1:0]       t_next
);

  localparam int SW = sum_width(NBITS, PBITS);

  logic [NBITS-1:0]       w_b_sel;
  logic [NBITS+PBITS-1:0] w_m_sel;
  logic [SW-1:0]          w_s;
  logic [SW-1:0]          w_u;
  logic [PBITS-1:0]       w_q;
  logic                   w_unused;

  always_comb begin
    w_b_sel = '0;
    for (int i = 1; i < MLSIZE; i++) begin
      if (d == PBITS'(i)) w_b_sel = bxn[i];
    end
  end

  assign w_s = SW'(t) + SW'(w_b_sel);
  assign w_q = PBITS'(w_s[PBITS-1:0] * minv);

  // The widened compare keeps every table entry referenced; q never reaches MLSIZE.
  always_comb begin
    w_m_sel = '0;
    for (int i = 1; i <= MLSIZE; i++) begin
      if ({1'b0, w_q} == (PBITS + 1)'(i)) w_m_sel = mxn[i];
    end
  end

  assign w_u      = w_s + SW'(w_m_sel);
  assign t_next   = w_u[SW-1:PBITS];
  assign w_unused = &{1'b0, w_u[PBITS-1:0]};

endmodule
`default_nettype wire

// File: rtl/mont_iter_core.sv
`default_nettype none
// ============================================================================
// Module  : mont_iter_core
// Purpose : Iterative Montgomery multiplier, res = a*b*2^-NBITS mod m.
//           Optional MONT_TBL_REUSE_EN adds reuse_tbl to skip the table build.
// Revision: 1.0 - initial release
// ============================================================================
module mont_iter_core
  import mont_pkg::*;
#(
  parameter int NBITS  = 4096,
  parameter int PBITS  = 1,
  parameter int MLSIZE = 1 << PBITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NBITS-1:0]       a,
  input  logic [NBITS-1:0]       m,
  input  logic [PBITS-1:0]       minv,
`ifdef MONT_TBL_REUSE_EN
  input  logic                   reuse_tbl,
`endif
  output logic                   enable_p,
  input  logic                   mxn_done,
  input  logic [NBITS+PBITS-1:0] mxn [1:MLSIZE],
  input  logic [NBITS-1:0]       bxn [1:MLSIZE-1],
  output logic                   busy,
  output logic                   done,
  output logic [NBITS-1:0]       res
);

  localparam int NDIG = ndig(NBITS, PBITS);
  localparam int CW   = $clog2(NDIG + 1);
  localparam int TW   = acc_width(NBITS);

  mont_state_e      r_state;
  mont_state_e      w_next;
  logic [NBITS-1:0] r_a;
  logic [TW-1:0]    r_t;
  logic [TW-1:0]    w_t_next;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_skip_tbl;

  assign w_accept = (r_state == ST_IDLE) && start;

`ifdef MONT_TBL_REUSE_EN
  logic r_tbl_valid;

  assign w_skip_tbl = reuse_tbl && r_tbl_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_tbl_valid <= 1'b0;
    else if ((r_state == ST_TBL) && mxn_done) r_tbl_valid <= 1'b1;
    else if (enable_p)                        r_tbl_valid <= 1'b0;
  end
`else
  assign w_skip_tbl = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != ST_IDLE);
    done   = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = w_skip_tbl ? ST_ITER : ST_TBL;
      ST_TBL:  if (mxn_done) w_next = ST_ITER;
      ST_ITER: if (r_cnt == CW'(NDIG - 1)) w_next = ST_RED;
      ST_RED:  w_next = ST_FIN;
      ST_FIN: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  mont_digit_step #(
    .NBITS (NBITS),
    .PBITS (PBITS),
    .MLSIZE(MLSIZE)
  ) u_step (
    .t     (r_t),
    .d     (r_a[PBITS-1:0]),
    .minv  (minv),
    .mxn   (mxn),
    .bxn   (bxn),
    .t_next(w_t_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_p <= 1'b0;
      r_a      <= '0;
      r_t      <= '0;
      r_cnt    <= '0;
      res      <= '0;
    end else begin
      enable_p <= w_accept && !w_skip_tbl;
      if (w_accept) begin
        r_a   <= a;
        r_t   <= '0;
        r_cnt <= '0;
      end else if (r_state == ST_ITER) begin
        r_a   <= r_a >> PBITS;
        r_t   <= w_t_next;
        r_cnt <= r_cnt + CW'(1);
      end
      // T < 2m, so one conditional subtraction fully reduces it.
      if (r_state == ST_RED)
        res <= (r_t >= TW'(m)) ? (r_t[NBITS-1:0] - m) : r_t[NBITS-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mont_iter_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_mont_iter_core
// Purpose : Directed checks of mont_iter_core at NBITS=8, m=13, PBITS=1 and 2.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mont_iter_core;

  typedef struct {
    int sel;
    int a;
    int b;
    int res;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_v    [2];
  logic       mxn_done_v [2];
  logic       reuse_v    [2];
  logic [7:0] a_v        [2];
  int         b_v        [2];
  logic       en_w       [2];
  logic       busy_w     [2];
  logic       done_w     [2];
  logic [7:0] res_w      [2];

  logic [8:0] mxn0 [1:2];
  logic [7:0] bxn0 [1:1];
  logic [9:0] mxn1 [1:4];
  logic [7:0] bxn1 [1:3];

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  // Upstream precompute model: tables follow the current b of each instance.
  always_comb begin
    bxn0[1] = 8'(b_v[0] % 13);
    for (int i = 1; i <= 2; i++) mxn0[i] = 9'(i * 13);
    for (int i = 1; i <= 3; i++) bxn1[i] = 8'((i * b_v[1]) % 13);
    for (int i = 1; i <= 4; i++) mxn1[i] = 10'(i * 13);
  end

  mont_iter_core #(.NBITS(8), .PBITS(1), .MLSIZE(2)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_v[0]),
    .a        (a_v[0]),
    .m        (8'd13),
    .minv     (1'b1),
`ifdef MONT_TBL_REUSE_EN
    .reuse_tbl(reuse_v[0]),
`endif
    .enable_p (en_w[0]),
    .mxn_done (mxn_done_v[0]),
    .mxn      (mxn0),
    .bxn      (bxn0),
    .busy     (busy_w[0]),
    .done     (done_w[0]),
    .res      (res_w[0])
  );

  mont_iter_core #(.NBITS(8), .PBITS(2), .MLSIZE(4)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_v[1]),
    .a        (a_v[1]),
    .m        (8'd13),
    .minv     (2'd3),
`ifdef MONT_TBL_REUSE_EN
    .reuse_tbl(reuse_v[1]),
`endif
    .enable_p (en_w[1]),
    .mxn_done (mxn_done_v[1]),
    .mxn      (mxn1),
    .bxn      (bxn1),
    .busy     (busy_w[1]),
    .done     (done_w[1]),
    .res      (res_w[1])
  );

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ndig_of(input int sel);
    return (sel == 0) ? 8 : 4;
  endfunction

  task automatic run_op(input int sel, input int av, input int bv, input int exp, input string name);
    int lat;
    bit got;
    a_v[sel] = 8'(av);
    b_v[sel] = bv;
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    check({name, " enable_p first TBL"}, int'(en_w[sel]), 1);
    @(negedge clk);
    check({name, " enable_p second TBL"}, int'(en_w[sel]), 0);
    mxn_done_v[sel] = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30 && !got; k++) begin
      @(negedge clk);
      if (k == 1) mxn_done_v[sel] = 1'b0;
      if (done_w[sel]) begin
        got = 1'b1;
        lat = k;
      end
    end
    check({name, " latency"}, lat, ndig_of(sel) + 2);
    check({name, " res"}, int'(res_w[sel]), exp);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    int   ndone;
    int   nen;
    int   nbusy;
    int   lat;
    bit   got;

    vecs[0] = '{0, 5, 7, 1};
    vecs[1] = '{0, 0, 7, 0};
    vecs[2] = '{0, 1, 9, 1};
    vecs[3] = '{0, 3, 4, 10};
    vecs[4] = '{0, 255, 12, 2};
    vecs[5] = '{1, 12, 12, 3};
    vecs[6] = '{1, 5, 7, 1};
    vecs[7] = '{1, 0, 7, 0};
    vecs[8] = '{1, 1, 9, 1};
    vecs[9] = '{1, 3, 4, 10};

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0;
      mxn_done_v[s] = 1'b0;
      reuse_v[s] = 1'b0;
      a_v[s] = 8'd0;
      b_v[s] = 0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset busy%0d", s), int'(busy_w[s]), 0);
      check($sformatf("reset done%0d", s), int'(done_w[s]), 0);
      check($sformatf("reset enable_p%0d", s), int'(en_w[s]), 0);
      check($sformatf("reset res%0d", s), int'(res_w[s]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++)
      run_op(vecs[v].sel, vecs[v].a, vecs[v].b, vecs[v].res, $sformatf("vec%0d", v));

    // start pulses during ITER and FIN must be ignored
    a_v[0] = 8'd5;
    b_v[0] = 7;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    mxn_done_v[0] = 1'b1;
    @(negedge clk);
    mxn_done_v[0] = 1'b0;
    a_v[0] = 8'd12;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (done_w[0]) got = 1'b1;
    end
    check("ign done seen", int'(got), 1);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    ndone = 0;
    nen = 0;
    nbusy = 0;
    for (int k = 0; k < 15; k++) begin
      if (done_w[0]) ndone++;
      if (en_w[0]) nen++;
      if (busy_w[0]) nbusy++;
      @(negedge clk);
    end
    check("ign extra done", ndone, 0);
    check("ign extra enable_p", nen, 0);
    check("ign busy after", nbusy, 0);
    check("ign res", int'(res_w[0]), 1);

    // asynchronous reset in the middle of ITER
    a_v[1] = 8'd12;
    b_v[1] = 12;
    @(negedge clk);
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    @(negedge clk);
    mxn_done_v[1] = 1'b1;
    @(negedge clk);
    mxn_done_v[1] = 1'b0;
    @(negedge clk);
    check("mid busy before rst", int'(busy_w[1]), 1);
    rst_n = 1'b0;
    #1;
    check("rst busy", int'(busy_w[1]), 0);
    check("rst done", int'(done_w[1]), 0);
    check("rst enable_p", int'(en_w[1]), 0);
    check("rst res1", int'(res_w[1]), 0);
    check("rst res0", int'(res_w[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 12, 12, 3, "post_rst");

`ifdef MONT_TBL_REUSE_EN
    run_op(0, 5, 7, 1, "reuse_build");
    reuse_v[0] = 1'b1;
    a_v[0] = 8'd3;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    nen = 0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30 && !got; k++) begin
      if (en_w[0]) nen++;
      if (done_w[0]) begin
        got = 1'b1;
        lat = k;
      end else begin
        @(negedge clk);
      end
    end
    check("reuse enable_p", nen, 0);
    check("reuse latency", lat, 10);
    check("reuse res", int'(res_w[0]), 11);
    reuse_v[0] = 1'b0;
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mont_iter_core.md
MONT_ITER_CORE -- requirements
Module: mont_iter_core

Interface
REQ-001 SHALL have parameter NBITS, default 4096, meaning operand/modulus width; NBITS SHALL be a multiple of PBITS.
REQ-002 SHALL have parameter PBITS, default 1, meaning digit width (radix 2^PBITS).
REQ-003 SHALL have parameter MLSIZE, default 1<<PBITS, meaning lookup table depth.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  meaning request a multiplication; sampled only in IDLE.
REQ-007 SHALL have port a  input  NBITS  meaning multiplier operand, consumed LSB-digit first.
REQ-008 SHALL have port m  input  NBITS  meaning odd modulus, held stable start..done.
REQ-009 SHALL have port minv  input  PBITS  meaning -m^-1 mod 2^PBITS.
REQ-010 SHALL have port enable_p  output  1  meaning one-cycle table-build request to the multiples precompute stage.
REQ-011 SHALL have port mxn_done  input  1  meaning one-cycle table-ready pulse from that stage.
REQ-012 SHALL have port mxn  input  MLSIZE entries [1:MLSIZE] x (NBITS+PBITS)  meaning mxn[i] = i*m.
REQ-013 SHALL have port bxn  input  MLSIZE-1 entries [1:MLSIZE-1] x NBITS  meaning bxn[i] = i*b mod m.
REQ-014 SHALL have port busy  output  1  meaning high in every state except IDLE.
REQ-015 SHALL have port done  output  1  meaning one-cycle pulse, res valid.
REQ-016 SHALL have port res  output  NBITS  meaning a*b*2^-NBITS mod m, fully reduced.

Function
REQ-017 FSM states SHALL be IDLE, TBL, ITER, RED, FIN; NDIG = NBITS/PBITS.
REQ-018 IDLE with start=1 SHALL latch a into shift register, clear accumulator T (NBITS+2 bits), clear digit counter, go to TBL; enable_p SHALL be registered and high exactly the first TBL cycle.
REQ-019 TBL SHALL wait for mxn_done=1, then go to ITER; mxn_done outside TBL SHALL be ignored.
REQ-020 Each ITER cycle: d = a digit j; S = T + (d==0 ? 0 : bxn[d]); q = (S[PBITS-1:0]*minv) mod 2^PBITS; T <= (S + (q==0 ? 0 : mxn[q])) >> PBITS; sum width NBITS+PBITS+2, no truncation before shift.
REQ-021 ITER SHALL last exactly NDIG cycles, then RED; invariant T < 2m.
REQ-022 RED SHALL register res <= (T >= m) ? T-m : T and go to FIN.
REQ-023 FIN SHALL assert done for one cycle and return to IDLE; res SHALL hold until the next RED.
REQ-024 start while busy SHALL be ignored; start in FIN SHALL be ignored (accepted only in IDLE).
REQ-025 Latency: mxn_done seen in cycle t -> done in cycle t+NDIG+2.

Reset
REQ-026 rst_n low SHALL force IDLE, enable_p=0, busy=0, done=0, res=0, T=0, counter=0, from any state, immediately.

Configuration
REQ-027 With MONT_TBL_REUSE_EN defined, input reuse_tbl (1 bit) SHALL exist; start with reuse_tbl=1 and table-valid flag set SHALL skip TBL (no enable_p) and enter ITER next cycle; flag set on mxn_done, cleared on reset and on every enable_p.
REQ-028 Without MONT_TBL_REUSE_EN, no reuse_tbl port; every start SHALL go through TBL.

Structure
REQ-029 Shared package mont_pkg SHALL hold the FSM state typedef and NDIG/width constant functions.
REQ-030 One combinational sub-module mont_digit_step SHALL implement the REQ-020 single-digit datapath.

Verification (NBITS=8, m=13, R^-1 mod 13 = 3; upstream model builds tables)
REQ-031 PBITS=1, minv=1, a=5, b=7 -> res=1, done exactly 10 cycles after mxn_done cycle.
REQ-032 PBITS=2, minv=3, a=12, b=12 -> res=3, done 6 cycles after mxn_done cycle.
REQ-033 a=0, b=7 -> res=0; a=1, b=9 -> res=1.
REQ-034 start pulsed during ITER and FIN -> ignored, single done, res unchanged by second start.
REQ-035 rst_n low mid-ITER -> all outputs 0, IDLE next; new start completes correctly.
REQ-036 MONT_TBL_REUSE_EN: second start with reuse_tbl=1 -> no enable_p, done NDIG+2 cycles after start-accept cycle, correct res.
